gray_conv_arbiter: RTL and testbench
====================================

Name: gray_conv_arbiter

Overview:
- Shares one binary-to-gray conversion datapath between two requesters.
- Each requester offers a binary word with a valid/ready handshake. A round-robin arbiter picks one per cycle.
- The word is converted combinationally, then captured into a single registered output stage with a valid/ready handshake and a requester ID.
- Sits in front of gray-coded consumers such as pointer synchronisers, encoder position buses and status displays.

Parameters:
- WIDTH, 4, bit width of the binary input and the gray output (≥ 2).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 offers req0_bin.
- req0_bin  in  WIDTH  requester 0 binary word.
- req0_ready  out  1  requester 0 word is accepted this cycle.
- req1_valid  in  1  requester 1 offers req1_bin.
- req1_bin  in  WIDTH  requester 1 binary word.
- req1_ready  out  1  requester 1 word is accepted this cycle.
- out_valid  out  1  out_gray and out_id hold a result.
- out_gray  out  WIDTH  gray code of the accepted word.
- out_id  out  1  requester that produced out_gray (0 or 1).
- out_ready  in  1  consumer takes the result this cycle.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_gray=0, out_id=0, last_grant=1, so requester 0 wins the first contention.
  - req0_ready and req1_ready are 0 while rst is high.
- Conversion: gray[WIDTH-1]=bin[WIDTH-1]; gray[i]=bin[i+1]^bin[i] for i<WIDTH-1. Purely combinational inside the sub-module.
- Output stage is one register with two states: EMPTY (out_valid=0) and FULL (out_valid=1).
- Accept condition: can_accept = !out_valid | out_ready. A full stage being drained this cycle may be refilled in the same cycle.
- Arbitration, evaluated only when can_accept=1:
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the requester ≠ last_grant.
  - Neither set: no grant.
- reqN_ready = can_accept & grant==N & !rst. It is combinational and depends on out_ready and the valids. At most one ready is high per cycle.
- On an accept edge:
  - out_gray ← conversion of the granted word.
  - out_id ← grant.
  - out_valid ← 1.
  - last_grant ← grant.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: one word per cycle while out_ready=1.
- Drain with no grant: out_valid ← 0.
- Hold when out_valid=1 and out_ready=0: out_gray and out_id are stable, both readys are 0, and last_grant is unchanged.
- Fairness: under continuous contention, grants alternate strictly 0,1,0,1. No requester waits more than one accepted transfer.
- A requester's valid may drop without being granted (no stickiness required). The bench must not rely on it staying asserted.
- Reset mid-operation discards any held result. The consumer sees out_valid fall on the reset edge, and the arbiter restarts with requester 0 priority.
- Wrap: all-ones input converts to 1 followed by zeros, e.g. 4'b1111 → 4'b1000. No overflow logic exists.

Decomposition:
- Shared package gray_pkg holds:
  - localparam DEFAULT_WIDTH=4.
  - localparams ID_REQ0=1'b0, ID_REQ1=1'b1.
  - A function or macro for the reference gray formula, reused by the bench scoreboard.
- One sub-module, bin2gray_core (parameter WIDTH; bin in, gray out, combinational). It is instantiated once, fed by a 2:1 mux selected by grant.
- Arbiter logic and the output register stay in gray_conv_arbiter.

Test Plan:
- Single requester, no backpressure: req0 sends 4'b1011 with out_ready=1 → next cycle out_valid=1, out_gray=4'b1110, out_id=0. Then 4'b0110 → 4'b0101.
- Contention after reset: both valid every cycle, req0_bin=4'b0111, req1_bin=4'b1111, out_ready=1 → outputs alternate (0100,id0),(1000,id1),(0100,id0)… starting with id0.
- Backpressure: result 4'b0011→4'b0010 held while out_ready=0 for 3 cycles → out_gray/out_id stable, req0_ready=req1_ready=0. On out_ready=1, the same-cycle refill is accepted.
- Drain to empty: single transfer, then both valids low → out_valid falls one cycle after the consumer handshake.
- Reset mid-hold: out_valid=1 and out_ready=0, assert rst one cycle → out_valid=0, out_gray=0. Next contention is granted to requester 0.
- Exhaustive: req1 sweeps 0..15 with random out_ready → every output matches the gray_pkg formula in order. No word is lost or duplicated (scoreboard count 16).

Source files
------------

// File: rtl/gray_pkg.sv
// Shared definitions for the gray conversion arbiter.
// Holds the default datapath width, requester IDs and a reference gray formula
// usable by both design-side code and verification scoreboards.
package gray_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic ID_REQ0 = 1'b0;
  localparam logic ID_REQ1 = 1'b1;

  // Reference binary-to-gray formula on a 32-bit container; callers truncate
  // to their own width. Upper bits stay zero when the input's upper bits are zero.
  function automatic logic [31:0] bin2gray_ref(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_core.sv
// Combinational binary-to-gray converter.
// Ports:
//   bin  - binary input word
//   gray - gray-coded output word (MSB passes through, lower bits XOR with neighbour)
module bin2gray_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  always_comb begin
    gray = '0;
    gray[WIDTH-1] = bin[WIDTH-1];
    for (int i = 0; i < int'(WIDTH) - 1; i++) begin
      gray[i] = bin[i+1] ^ bin[i];
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter sharing a single binary-to-gray converter,
// followed by one registered output slot with a valid/ready handshake.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   req0_valid/req0_bin/req0_ready - requester 0 handshake and binary word
//   req1_valid/req1_bin/req1_ready - requester 1 handshake and binary word
//   out_valid/out_gray/out_id      - registered result, source requester ID
//   out_ready                      - consumer takes the result this cycle
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_bin,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_bin,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_gray,
  output logic             out_id,
  input  logic             out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_gray_q, out_gray_d;
  logic             out_id_q, out_id_d;
  logic             last_grant_q, last_grant_d;

  logic             can_accept;
  logic             has_grant;
  logic             grant;
  logic [WIDTH-1:0] sel_bin;
  logic [WIDTH-1:0] sel_gray;

  // The output slot is free when empty or when its current result leaves this cycle.
  assign can_accept = !out_valid_q || out_ready;

  always_comb begin
    has_grant = 1'b0;
    grant     = ID_REQ0;
    if (can_accept) begin
      if (req0_valid && req1_valid) begin
        has_grant = 1'b1;
        grant     = ~last_grant_q;
      end else if (req0_valid) begin
        has_grant = 1'b1;
        grant     = ID_REQ0;
      end else if (req1_valid) begin
        has_grant = 1'b1;
        grant     = ID_REQ1;
      end
    end
  end

  assign req0_ready = has_grant && (grant == ID_REQ0) && !rst;
  assign req1_ready = has_grant && (grant == ID_REQ1) && !rst;

  assign sel_bin = (grant == ID_REQ1) ? req1_bin : req0_bin;

  bin2gray_core #(
    .WIDTH(WIDTH)
  ) u_bin2gray_core (
    .bin (sel_bin),
    .gray(sel_gray)
  );

  always_comb begin
    out_valid_d  = out_valid_q;
    out_gray_d   = out_gray_q;
    out_id_d     = out_id_q;
    last_grant_d = last_grant_q;
    if (has_grant) begin
      out_valid_d  = 1'b1;
      out_gray_d   = sel_gray;
      out_id_d     = grant;
      last_grant_d = grant;
    end else if (out_ready) begin
      // Drained with nothing to refill; data fields keep their last value.
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_gray_q   <= '0;
      out_id_q     <= ID_REQ0;
      // Pretend requester 1 went last so requester 0 wins the first contention.
      last_grant_q <= ID_REQ1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_gray_q   <= out_gray_d;
      out_id_q     <= out_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_gray  = out_gray_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
module tb_gray_conv_arbiter;
  import gray_pkg::*;

  localparam int unsigned W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_bin, req1_bin;
  logic         req0_ready, req1_ready;
  logic         out_valid, out_id, out_ready;
  logic [W-1:0] out_gray;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gray_conv_arbiter #(
    .WIDTH(W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_bin  (req0_bin),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_bin  (req1_bin),
    .req1_ready(req1_ready),
    .out_valid (out_valid),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  typedef struct packed {
    logic         rst;
    logic         v0;
    logic [W-1:0] b0;
    logic         v1;
    logic [W-1:0] b1;
    logic         ordy;
    logic         e_r0;
    logic         e_r1;
    logic         e_ov;
    logic         chk;   // compare gray/id after the edge
    logic [W-1:0] e_gray;
    logic         e_id;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic v0, input logic [W-1:0] b0,
                     input logic v1, input logic [W-1:0] b1, input logic ordy,
                     input logic e_r0, input logic e_r1, input logic e_ov,
                     input logic c, input logic [W-1:0] e_gray, input logic e_id);
    vec_t v;
    v = '{r, v0, b0, v1, b1, ordy, e_r0, e_r1, e_ov, c, e_gray, e_id};
    vecs.push_back(v);
  endtask

  initial begin
    int          sent;
    int          got;
    int          cycles;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] e;

    rst = 1'b1; req0_valid = 0; req1_valid = 0; req0_bin = '0; req1_bin = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_gray", 32'(out_gray), 0);
    chk("reset_ready0", 32'(req0_ready), 0);
    rst = 1'b0;

    //   rst v0 b0       v1 b1       ordy r0 r1 ov chk gray     id
    // single requester
    add(0, 1, 4'b1011, 0, 4'b0000, 1,  1, 0, 1, 1, 4'b1110, 0);
    add(0, 1, 4'b0110, 0, 4'b0000, 1,  1, 0, 1, 1, 4'b0101, 0);
    // reset, then contention alternates starting with requester 0
    add(1, 1, 4'b0111, 1, 4'b1111, 1,  0, 0, 0, 1, 4'b0000, 0);
    add(0, 1, 4'b0111, 1, 4'b1111, 1,  1, 0, 1, 1, 4'b0100, 0);
    add(0, 1, 4'b0111, 1, 4'b1111, 1,  0, 1, 1, 1, 4'b1000, 1);
    add(0, 1, 4'b0111, 1, 4'b1111, 1,  1, 0, 1, 1, 4'b0100, 0);
    add(0, 1, 4'b0111, 1, 4'b1111, 1,  0, 1, 1, 1, 4'b1000, 1);
    // backpressure: hold three cycles, then same-cycle refill
    add(0, 1, 4'b0011, 0, 4'b0000, 1,  1, 0, 1, 1, 4'b0010, 0);
    add(0, 1, 4'b0101, 1, 4'b0001, 0,  0, 0, 1, 1, 4'b0010, 0);
    add(0, 1, 4'b0101, 1, 4'b0001, 0,  0, 0, 1, 1, 4'b0010, 0);
    add(0, 1, 4'b0101, 1, 4'b0001, 0,  0, 0, 1, 1, 4'b0010, 0);
    add(0, 1, 4'b0101, 1, 4'b0001, 1,  0, 1, 1, 1, 4'b0001, 1);
    add(0, 0, 4'b0000, 0, 4'b0000, 1,  0, 0, 0, 0, 4'b0000, 0);
    // drain to empty (wrap value 1111 -> 1000)
    add(0, 1, 4'b1111, 0, 4'b0000, 0,  1, 0, 1, 1, 4'b1000, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 0,  0, 0, 1, 1, 4'b1000, 0);
    add(0, 0, 4'b0000, 0, 4'b0000, 1,  0, 0, 0, 0, 4'b0000, 0);
    // reset mid-hold, then requester 0 regains priority
    add(0, 1, 4'b0010, 0, 4'b0000, 1,  1, 0, 1, 1, 4'b0011, 0);
    add(0, 0, 4'b0000, 1, 4'b0100, 0,  0, 0, 1, 1, 4'b0011, 0);
    add(1, 0, 4'b0000, 1, 4'b0100, 0,  0, 0, 0, 1, 4'b0000, 0);
    add(0, 1, 4'b0001, 1, 4'b0010, 1,  1, 0, 1, 1, 4'b0001, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      req0_valid = vecs[i].v0; req0_bin = vecs[i].b0;
      req1_valid = vecs[i].v1; req1_bin = vecs[i].b1;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vecs[i].e_r0));
      chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vecs[i].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].e_ov));
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_out_gray", i), 32'(out_gray), 32'(vecs[i].e_gray));
        chk($sformatf("v%0d_out_id", i), 32'(out_id), 32'(vecs[i].e_id));
      end
    end

    // Exhaustive sweep on requester 1 with random backpressure and a scoreboard.
    rst = 1'b1; req0_valid = 0; req1_valid = 0; out_ready = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sent = 0; got = 0; cycles = 0;
    while (got < 16 && cycles < 400) begin
      req1_valid = (sent < 16);
      req1_bin   = W'(sent);
      out_ready  = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("sweep_unexpected_output", 32'(out_gray), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("sweep_gray_%0d", got), 32'(out_gray), 32'(e));
          chk($sformatf("sweep_id_%0d", got), 32'(out_id), 32'(ID_REQ1));
        end
        got++;
      end
      if (req1_ready) begin
        exp_q.push_back(W'(bin2gray_ref(32'(sent))));
        sent++;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    chk("sweep_count", 32'(got), 16);
    chk("sweep_sent", 32'(sent), 16);
    chk("sweep_leftover", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
